// File: rtl/vit_pkg.sv
// Shared types and helpers for the ViT encoder output-side token streamer.
package vit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } tok_stream_state_t;

    // Element offset of token t inside a flattened frame.
    function automatic int row_offset(input int t, input int emb_dim);
        return t * emb_dim;
    endfunction

endpackage

// File: rtl/vit_token_streamer.sv
// Captures one flattened SEQ_LEN x EMB_DIM frame and replays it as a valid/ready token stream.
//
// state    | meaning
// S_IDLE   | frame_ready high, waiting for a frame_valid pulse
// S_STREAM | presenting buffer row idx on tok_data until handshaked
// S_DONE   | one-cycle frame_done pulse, then back to S_IDLE
module vit_token_streamer
    import vit_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  SEQ_LEN    = 16,
    parameter int  EMB_DIM    = 16,
    localparam int IDX_W      = $clog2(SEQ_LEN)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 frame_valid,
    input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] frame_in,
    output logic                                 frame_ready,
    output logic                                 tok_valid,
    input  logic                                 tok_ready,
    output logic [DATA_WIDTH*EMB_DIM-1:0]         tok_data,
    output logic [IDX_W-1:0]                     tok_idx,
    output logic                                 tok_last,
    output logic                                 frame_done,
    output logic                                 overflow,
    input  logic                                 clr_overflow
);

    localparam int               TOK_W    = DATA_WIDTH * EMB_DIM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    tok_stream_state_t state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic [TOK_W-1:0]  buf_q  [SEQ_LEN];
    logic [TOK_W-1:0]  buf_d  [SEQ_LEN];
    logic [TOK_W-1:0]  row_in [SEQ_LEN];

    for (genvar t = 0; t < SEQ_LEN; t++) begin : g_row_in
        assign row_in[t] = frame_in[DATA_WIDTH*row_offset(t, EMB_DIM) +: TOK_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            for (int t = 0; t < SEQ_LEN; t++) begin
                buf_q[t] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        overflow_d  = overflow_q;
        frame_ready = 1'b0;
        tok_valid   = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    buf_d   = row_in;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                tok_valid = 1'b1;
                if (tok_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                idx_d      = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A dropped frame must stay flagged even if software clears in the same cycle.
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (frame_valid && !frame_ready) begin
            overflow_d = 1'b1;
        end
    end

    assign tok_data = tok_valid ? buf_q[idx_q] : '0;
    assign tok_idx  = tok_valid ? idx_q : '0;
    assign tok_last = tok_valid && (idx_q == LAST_IDX);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vit_token_streamer.sv
// Directed + randomized bench for vit_token_streamer against a frame-array reference model.
module tb_vit_token_streamer;

    localparam int DW    = 16;
    localparam int SEQ   = 16;
    localparam int EMB   = 16;
    localparam int IDX_W = $clog2(SEQ);
    localparam int TW    = DW * EMB;
    localparam int FW    = DW * SEQ * EMB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_valid = 1'b0;
    logic [FW-1:0]    frame_in = '0;
    logic             frame_ready;
    logic             tok_valid;
    logic             tok_ready = 1'b0;
    logic [TW-1:0]    tok_data;
    logic [IDX_W-1:0] tok_idx;
    logic             tok_last;
    logic             frame_done;
    logic             overflow;
    logic             clr_overflow = 1'b0;

    vit_token_streamer #(.DATA_WIDTH(DW), .SEQ_LEN(SEQ), .EMB_DIM(EMB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_valid  (frame_valid),
        .frame_in     (frame_in),
        .frame_ready  (frame_ready),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_data     (tok_data),
        .tok_idx      (tok_idx),
        .tok_last     (tok_last),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit ovf_exp = 1'b0;
    logic [DW-1:0] mdl [SEQ][EMB];

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_model(input bit rnd);
        for (int t = 0; t < SEQ; t++)
            for (int e = 0; e < EMB; e++)
                mdl[t][e] = rnd ? DW'($urandom) : DW'(t * 16 + e);
    endtask

    function automatic logic [FW-1:0] pack_frame();
        logic [FW-1:0] f = '0;
        for (int t = 0; t < SEQ; t++)
            for (int e = 0; e < EMB; e++)
                f[(t*EMB+e)*DW +: DW] = mdl[t][e];
        return f;
    endfunction

    function automatic logic [TW-1:0] exp_row(input int t);
        logic [TW-1:0] r = '0;
        for (int e = 0; e < EMB; e++) r[e*DW +: DW] = mdl[t][e];
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f = '0;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // Called at a negedge; frame is captured on the following posedge.
    task automatic send_frame();
        frame_valid = 1'b1;
        frame_in    = pack_frame();
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_ready", frame_ready, 1);
            chk("idle_valid", tok_valid, 0);
            chk("idle_data", tok_data, 0);
            chk("idle_idx", tok_idx, 0);
            chk("idle_done", frame_done, 0);
            chk("idle_ovf", overflow, ovf_exp);
            @(negedge clk);
        end
    endtask

    // Entered one negedge after the capture edge. inj_tok>=0 pulses a junk frame
    // while that token is shown (optionally with clr_overflow); inj_done pulses one in S_DONE.
    task automatic stream(input bit bp, input int inj_tok, input bit inj_clr,
                          input bit inj_done, output int cycles);
        int nxt = 0;
        bit injected = 1'b0;
        bit fv, clr, hs;
        cycles = 0;
        while (nxt < SEQ && cycles < 2000) begin
            chk("tok_valid", tok_valid, 1);
            chk("busy_ready", frame_ready, 0);
            chk("busy_done", frame_done, 0);
            chk("tok_idx", tok_idx, nxt);
            chk("tok_data", tok_data, exp_row(nxt));
            chk("tok_last", tok_last, (nxt == SEQ - 1));
            fv = 1'b0;
            clr = 1'b0;
            if (inj_tok == nxt && !injected) begin
                fv = 1'b1;
                clr = inj_clr;
                injected = 1'b1;
                frame_in = rand_frame();
            end
            frame_valid  = fv;
            clr_overflow = clr;
            tok_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = tok_ready;
            @(negedge clk);
            frame_valid  = 1'b0;
            clr_overflow = 1'b0;
            if (fv) ovf_exp = 1'b1;
            else if (clr) ovf_exp = 1'b0;
            chk("stream_ovf", overflow, ovf_exp);
            if (hs) nxt++;
            cycles++;
        end
        chk("tok_count", nxt, SEQ);
        tok_ready = 1'b0;
        chk("done_pulse", frame_done, 1);
        chk("done_valid", tok_valid, 0);
        chk("done_data", tok_data, 0);
        chk("done_idx", tok_idx, 0);
        chk("done_ready", frame_ready, 0);
        if (inj_done) begin
            frame_valid = 1'b1;
            frame_in = rand_frame();
        end
        @(negedge clk);
        frame_valid = 1'b0;
        if (inj_done) ovf_exp = 1'b1;
        chk("post_ready", frame_ready, 1);
        chk("post_done", frame_done, 0);
        chk("post_valid", tok_valid, 0);
        chk("post_ovf", overflow, ovf_exp);
    endtask

    initial begin
        int cyc;

        // 1. reset and idle
        repeat (2) @(negedge clk);
        chk("rst_ready", frame_ready, 1);
        chk("rst_valid", tok_valid, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk(2);

        // 2. counting pattern, no backpressure, exact latency
        set_model(1'b0);
        send_frame();
        stream(1'b0, -1, 1'b0, 1'b0, cyc);
        chk("latency", cyc, SEQ);
        idle_chk(1);

        // 3. random data with random backpressure
        for (int k = 0; k < 2; k++) begin
            set_model(1'b1);
            send_frame();
            stream(1'b1, -1, 1'b0, 1'b0, cyc);
            idle_chk(1);
        end

        // 4. overflow: drop at token 5, sticky, clear alone, set beats clear
        set_model(1'b0);
        send_frame();
        stream(1'b0, 5, 1'b0, 1'b0, cyc);
        idle_chk(3);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        ovf_exp = 1'b0;
        chk("clr_alone", overflow, 0);
        set_model(1'b1);
        send_frame();
        stream(1'b1, 3, 1'b1, 1'b0, cyc);
        chk("set_wins", overflow, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        ovf_exp = 1'b0;
        idle_chk(1);

        // 5. frame in S_DONE dropped, next cycle accepted
        set_model(1'b1);
        send_frame();
        stream(1'b0, -1, 1'b0, 1'b1, cyc);
        set_model(1'b1);
        send_frame();
        stream(1'b1, -1, 1'b0, 1'b0, cyc);
        idle_chk(1);

        // 6. reset at token 7
        set_model(1'b1);
        send_frame();
        tok_ready = 1'b1;
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("pre_rst_idx", tok_idx, 7);
        rst_n = 1'b0;
        ovf_exp = 1'b0;
        #1;
        chk("mid_rst_valid", tok_valid, 0);
        chk("mid_rst_data", tok_data, 0);
        chk("mid_rst_idx", tok_idx, 0);
        chk("mid_rst_last", tok_last, 0);
        chk("mid_rst_ready", frame_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_done", frame_done, 0);
        end
        rst_n = 1'b1;
        tok_ready = 1'b0;
        @(negedge clk);
        idle_chk(2);
        set_model(1'b1);
        send_frame();
        stream(1'b1, -1, 1'b0, 1'b0, cyc);
        idle_chk(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vit_token_streamer.md
Name: vit_token_streamer

Overview:
Output-side reader for the ViT encoder block's frame interface. It captures one flattened (SEQ_LEN x EMB_DIM) frame on the encoder's done/out_valid pulse. It then replays that frame as a valid/ready token stream, one EMB_DIM-wide token per handshake, to downstream per-token consumers (next stage, classifier head, DMA). It is the serializing counterpart to the encoder's frame-parallel output.

Parameters:
DATA_WIDTH, 16, bit width of one element
SEQ_LEN, 16, tokens per frame (>=2)
EMB_DIM, 16, elements per token
IDX_W, $clog2(SEQ_LEN) (localparam), width of the token index

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
frame_valid  input  1  single-cycle pulse; frame_in is valid this cycle
frame_in  input  [DATA_WIDTH] x [SEQ_LEN*EMB_DIM]  flattened frame; token t, element e at index t*EMB_DIM+e
frame_ready  output  1  high only in S_IDLE; block can accept a frame
tok_valid  output  1  token on tok_data is valid
tok_ready  input  1  downstream accepts token
tok_data  output  [DATA_WIDTH] x [EMB_DIM]  current token
tok_idx  output  IDX_W  index of current token
tok_last  output  1  tok_valid and tok_idx==SEQ_LEN-1
frame_done  output  1  one-cycle pulse after last token handshake
overflow  output  1  sticky; frame_valid seen while frame_ready=0
clr_overflow  input  1  clears overflow

Behaviour:
- Clock and reset: clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=S_IDLE; all buffer entries 0; idx=0; tok_valid=0; tok_last=0; frame_done=0; overflow=0; frame_ready=1 (combinational from S_IDLE); tok_data=0.
- FSM states: S_IDLE, S_STREAM, S_DONE.
- S_IDLE:
  - frame_ready=1.
  - On frame_valid, register all SEQ_LEN*EMB_DIM elements into the buffer, set idx=0, and go to S_STREAM.
- S_STREAM:
  - tok_valid=1; tok_data = buffer row idx; tok_idx=idx.
  - On tok_valid&&tok_ready: if idx==SEQ_LEN-1, go to S_DONE; else idx<=idx+1.
  - tok_data and tok_idx are held stable while tok_valid&&!tok_ready. No token is skipped or repeated.
- S_DONE: frame_done=1 for exactly one cycle, idx<=0, then return to S_IDLE.
- Latency:
  - Frame captured at edge N; first token valid from N+1.
  - With tok_ready held high, tokens occupy cycles N+1..N+SEQ_LEN, frame_done at N+SEQ_LEN+1, and frame_ready is high again at N+SEQ_LEN+2.
  - Backpressure extends the sequence one cycle per stall cycle.
- tok_data is gated to 0 whenever tok_valid=0. tok_idx reads 0 outside S_STREAM.
- Overflow:
  - frame_valid while frame_ready=0 (S_STREAM or S_DONE) is ignored: buffer untouched, stream continues, overflow<=1.
  - clr_overflow clears overflow. If set and clear occur in the same cycle, set wins.
- Simultaneous events:
  - frame_valid in the S_DONE cycle: dropped and flagged as overflow.
  - A frame is accepted only in S_IDLE.
- Reset mid-stream: asynchronous return to reset values. A partially emitted frame is abandoned; no frame_done.
- No arithmetic is performed on data; elements pass through bit-exact.

Decomposition:
- Shared package vit_pkg holds:
  - the state typedef (tok_stream_state_t: S_IDLE, S_STREAM, S_DONE)
  - the helper function for the token-row offset (t*EMB_DIM)
- IDX_W is a local parameter.
- No sub-module is needed; the row-select mux stays inline. A single module of roughly 150 RTL lines.

Test Plan:
1. Reset, then idle: frame_ready=1, tok_valid=0, overflow=0, tok_data all 0.
2. Single frame with element (t,e) = t*16+e, tok_ready held 1:
   - tokens 0..15 appear on consecutive cycles N+1..N+16 with tok_data[e]=t*16+e;
   - tok_last only on token 15;
   - frame_done at N+17;
   - frame_ready high at N+18.
3. Random tok_ready backpressure (~50% duty): tok_data and tok_idx are stable during stalls, all 16 tokens arrive in order exactly once, and frame_done fires once.
4. Overflow:
   - frame_valid pulse at token 5 with a different pattern: stream output unchanged (still frame 1 data), overflow=1 and stays 1 through a second idle period.
   - clr_overflow asserted alone clears it.
   - clr_overflow asserted together with a new frame_valid during streaming leaves overflow=1.
5. Frames back-to-back: second frame_valid in the S_DONE cycle is dropped with overflow=1. A frame_valid one cycle later, in S_IDLE, is accepted and streams correctly.
6. Reset mid-stream: assert rst_n low at token 7. All outputs return to reset values, no frame_done pulse. A fresh frame afterwards streams from token 0.
